// File: rtl/reg_src_pkg.sv
// Shared datapath constants for the write-back source select.
package reg_src_pkg;
    localparam int   DATA_W       = 8;
    localparam logic REG_SRC_ALU  = 1'b0;
    localparam logic REG_SRC_DMEM = 1'b1;
endpackage

// File: rtl/reg_src_if.sv
// Write-back bus: ALU/DMem data in, selected and registered write data out.
interface reg_src_if
    import reg_src_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [WIDTH-1:0] from_ALU;
    logic [WIDTH-1:0] from_DMem;
    logic             Reg_src_cntrl;
    logic [WIDTH-1:0] to_reg;
    logic [WIDTH-1:0] to_reg_q;
    logic             src_q;

    modport master (
        output from_ALU, from_DMem, Reg_src_cntrl,
        input  to_reg, to_reg_q, src_q
    );

    modport slave (
        input  from_ALU, from_DMem, Reg_src_cntrl,
        output to_reg, to_reg_q, src_q
    );
endinterface

// File: rtl/reg_src.sv
// Register-file write-back source mux with a registered copy for pipeline/debug.
module reg_src
    import reg_src_pkg::*;
(
    input logic     clk,
    input logic     rst,
    reg_src_if.slave bus
);
    // Only an explicit DMem select picks memory data; reset never touches this path.
    assign bus.to_reg = (bus.Reg_src_cntrl == REG_SRC_DMEM) ? bus.from_DMem : bus.from_ALU;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.to_reg_q <= '0;
            bus.src_q    <= REG_SRC_ALU;
        end else begin
            bus.to_reg_q <= bus.to_reg;
            bus.src_q    <= bus.Reg_src_cntrl;
        end
    end
endmodule

// File: tb/tb_reg_src.sv
// Directed-vector bench for reg_src: mux table, registered path, reset, random sweep.
module tb_reg_src;
    import reg_src_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    reg_src_if #(.WIDTH(DATA_W)) bus ();

    reg_src dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] alu;
        logic [7:0] dmem;
        logic       cntrl;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] alu, input logic [7:0] dmem, input logic cntrl);
        bus.from_ALU      = alu;
        bus.from_DMem     = dmem;
        bus.Reg_src_cntrl = cntrl;
    endtask

    initial begin
        logic [7:0] ra, rd, exp_q;
        logic       rc, exp_src;

        vecs[0]  = '{"sel_alu",        8'h00, 8'h08, 1'b0, 8'h00};
        vecs[1]  = '{"sel_dmem",       8'h00, 8'h08, 1'b1, 8'h08};
        vecs[2]  = '{"iso_alu_change", 8'h04, 8'h08, 1'b1, 8'h08};
        vecs[3]  = '{"iso_dmem_change",8'h04, 8'h0C, 1'b1, 8'h0C};
        vecs[4]  = '{"iso_back_alu",   8'h04, 8'h0C, 1'b0, 8'h04};
        vecs[5]  = '{"ext_alu_ff",     8'hFF, 8'h00, 1'b0, 8'hFF};
        vecs[6]  = '{"ext_dmem_00",    8'hFF, 8'h00, 1'b1, 8'h00};
        vecs[7]  = '{"swap_alu_00",    8'h00, 8'hFF, 1'b0, 8'h00};
        vecs[8]  = '{"swap_dmem_ff",   8'h00, 8'hFF, 1'b1, 8'hFF};
        vecs[9]  = '{"simul_all",      8'hA5, 8'h5A, 1'b0, 8'hA5};
        vecs[10] = '{"simul_flip",     8'h3C, 8'hC3, 1'b1, 8'hC3};
        vecs[11] = '{"bits_alt",       8'h81, 8'h7E, 1'b0, 8'h81};

        // Reset state, with the combinational path live during reset.
        drive(8'h11, 8'h22, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_to_reg_q", 32'(bus.to_reg_q), 32'h00);
        check("rst_src_q",    32'(bus.src_q),    32'h0);
        check("rst_to_reg",   32'(bus.to_reg),   32'h22);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].alu, vecs[i].dmem, vecs[i].cntrl);
            #1;
            check(vecs[i].name, 32'(bus.to_reg), 32'(vecs[i].exp));
        end

        // Registered path: 1-cycle latency, old value holds before the edge.
        @(negedge clk);
        drive(8'h04, 8'h0C, 1'b0);
        @(posedge clk); #1;
        check("q_alu",  32'(bus.to_reg_q), 32'h04);
        check("sq_alu", 32'(bus.src_q),    32'h0);
        @(negedge clk);
        bus.Reg_src_cntrl = 1'b1;
        #1;
        check("pre_edge_to_reg", 32'(bus.to_reg),   32'h0C);
        check("pre_edge_q",      32'(bus.to_reg_q), 32'h04);
        check("pre_edge_sq",     32'(bus.src_q),    32'h0);
        @(posedge clk); #1;
        check("q_dmem",  32'(bus.to_reg_q), 32'h0C);
        check("sq_dmem", 32'(bus.src_q),    32'h1);

        // Mid-operation reset for one clock.
        @(negedge clk);
        rst = 1'b1;
        drive(8'h55, 8'hAA, 1'b0);
        #1;
        check("rst_mid_to_reg", 32'(bus.to_reg), 32'h55);
        @(posedge clk); #1;
        check("rst_mid_q",      32'(bus.to_reg_q), 32'h00);
        check("rst_mid_sq",     32'(bus.src_q),    32'h0);
        check("rst_mid_to_reg2",32'(bus.to_reg),   32'h55);
        @(negedge clk);
        rst = 1'b0;
        bus.Reg_src_cntrl = 1'b1;
        #1;
        check("rst_rel_hold_q", 32'(bus.to_reg_q), 32'h00);
        @(posedge clk); #1;
        check("rst_rel_q",  32'(bus.to_reg_q), 32'hAA);
        check("rst_rel_sq", 32'(bus.src_q),    32'h1);

        // Random sweep: mux every sample, registers against a one-cycle model.
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            ra = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            drive(ra, rd, rc);
            exp_q   = rc ? rd : ra;
            exp_src = rc;
            #1;
            check("rand_to_reg", 32'(bus.to_reg), 32'(exp_q));
            @(posedge clk); #1;
            check("rand_q",  32'(bus.to_reg_q), 32'(exp_q));
            check("rand_sq", 32'(bus.src_q),    32'(exp_src));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
